// File: rtl/mem_dump_tx.sv
// Memory-dump transmitter: reads RAM addresses 0..DEPTH-1 in order and sends
// each byte on a UART tx line (8N1, LSB first). All outputs are registered.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [7:0]        ram_out,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    START,
    DATA,
    STOP,
    NEXT
  } state_t;

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Compare against the last address before incrementing, so a full
  // 2**ADDR_W dump ends on all-ones without wrapping first.
  localparam logic [ADDR_W-1:0] ADR_LAST  = ADDR_W'(DEPTH - 1);

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_cnt, bit_n;
  logic [7:0]          shreg, shreg_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                en_q, en_n;
  logic [ADDR_W-1:0]   adr_q, adr_n;
  logic                baud_last;

  assign ram_adr    = adr_q;
  assign ram_enable = en_q;
  assign ram_rw     = 1'b0;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next-state and next-output computation; outputs are derived from the
  // upcoming state so they change together with it.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    busy_n    = busy_q;
    done_n    = 1'b0;
    adr_n     = adr_q;
    baud_last = (baud == BAUD_LAST);

    case (state)
      IDLE: begin
        if (start) begin
          busy_n  = 1'b1;
          adr_n   = '0;
          state_n = RD_REQ;
        end
      end
      RD_REQ: begin
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        shreg_n = ram_out;
        baud_n  = '0;
        bit_n   = '0;
        state_n = START;
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = NEXT;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      NEXT: begin
        if (adr_q == ADR_LAST) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          adr_n   = '0;
          state_n = IDLE;
        end else begin
          adr_n   = adr_q + 1'b1;
          state_n = RD_REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    en_n = (state_n == RD_REQ);

    // tx taps the registered shift register, never ram_out directly.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  // State and output registers; reset wins over ce, ce low holds all but done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      adr_q   <= '0;
    end else if (ce) begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      en_q    <= en_n;
      adr_q   <= adr_n;
    end else begin
      done_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx with CLKS_PER_BIT=4, DEPTH=4.
module tb_mem_dump_tx;

  localparam int NS = 176;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       start;
  logic [7:0] ram_out;
  logic [7:0] ram_adr;
  logic       ram_enable;
  logic       ram_rw;
  logic       tx;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  logic [7:0] mem [0:3];
  logic [7:0] exp_bytes [0:3];

  logic       tx_s   [0:NS-1];
  logic       done_s [0:NS-1];
  logic       busy_s [0:NS-1];
  logic       en_s   [0:NS-1];
  logic [7:0] adr_s  [0:NS-1];
  int         n_samp;

  mem_dump_tx #(
    .CLKS_PER_BIT(4),
    .ADDR_W(8),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .start(start),
    .ram_out(ram_out),
    .ram_adr(ram_adr),
    .ram_enable(ram_enable),
    .ram_rw(ram_rw),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_enable) ram_out <= mem[ram_adr[1:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and record outputs after every ce-qualified edge; index 0 is
  // the first RD_REQ cycle. With toggle set, ce alternates from index 10.
  task automatic run_dump(input bit toggle);
    int cyc;
    ce = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_samp = 0;
    tx_s[0] = tx; done_s[0] = done; busy_s[0] = busy;
    en_s[0] = ram_enable; adr_s[0] = ram_adr;
    n_samp = 1;
    cyc = 0;
    while (n_samp < NS && cyc < 2000) begin
      ce = (toggle && n_samp >= 10) ? cyc[0] : 1'b1;
      step();
      if (ce) begin
        tx_s[n_samp] = tx; done_s[n_samp] = done; busy_s[n_samp] = busy;
        en_s[n_samp] = ram_enable; adr_s[n_samp] = ram_adr;
        n_samp++;
      end
      cyc++;
    end
    ce = 1'b1;
  endtask

  function automatic logic [7:0] decode(input int k);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = tx_s[43*k + 6 + 4*b];
    return d;
  endfunction

  // Start slot low, stop slot high, gap cycles high, every slot 4 samples flat.
  function automatic bit frame_shape_ok(input int k);
    int base;
    bit ok;
    base = 43*k;
    ok = tx_s[base] && tx_s[base+1] && tx_s[base+42];
    for (int s = 0; s < 10; s++) begin
      for (int j = 1; j < 4; j++)
        if (tx_s[base+2+4*s+j] !== tx_s[base+2+4*s]) ok = 1'b0;
    end
    if (tx_s[base+2] !== 1'b0) ok = 1'b0;
    if (tx_s[base+38] !== 1'b1) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ce = 1'b1;
    repeat (3) step();
    checks++;
    if ({tx, busy, done, ram_enable, ram_rw} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: tx,busy,done,en,rw=%b required 10000",
               {tx, busy, done, ram_enable, ram_rw});
    end
    checks++;
    if (ram_adr !== 8'h00) begin
      errors++;
      $display("FAIL reset_adr: got %h required 00", ram_adr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (ram_enable !== 1'b1 || ram_adr !== 8'h00 || ram_rw !== 1'b0) begin
      errors++;
      $display("FAIL first_rd_req: en=%b adr=%h rw=%b required en=1 adr=00 rw=0",
               ram_enable, ram_adr, ram_rw);
    end
    step();
    checks++;
    if (ram_enable !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rd_wait: en=%b tx=%b required en=0 tx=1", ram_enable, tx);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (tx !== fr[i/4]) begin
        errors++;
        $display("FAIL frame_a5 cycle %0d: tx=%b required %b", i, tx, fr[i/4]);
      end
    end
    step();
    checks++;
    if (tx !== 1'b1 || ram_enable !== 1'b0) begin
      errors++;
      $display("FAIL next_gap: tx=%b en=%b required tx=1 en=0", tx, ram_enable);
    end
    step();
    checks++;
    if (ram_enable !== 1'b1 || ram_adr !== 8'h01) begin
      errors++;
      $display("FAIL second_rd_req: en=%b adr=%h required en=1 adr=01",
               ram_enable, ram_adr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_dump();
    run_dump(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (decode(k) !== exp_bytes[k]) begin
        errors++;
        $display("FAIL full_byte%0d: got %h required %h", k, decode(k), exp_bytes[k]);
      end
      checks++;
      if (!frame_shape_ok(k)) begin
        errors++;
        $display("FAIL full_shape%0d: frame timing wrong, got 0 required 1", k);
      end
      checks++;
      if (en_s[43*k] !== 1'b1 || adr_s[43*k] !== 8'(k)) begin
        errors++;
        $display("FAIL full_rdreq%0d: en=%b adr=%h required en=1 adr=%h",
                 k, en_s[43*k], adr_s[43*k], 8'(k));
      end
    end
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (done_s[i] !== (i == 172) || busy_s[i] !== (i < 172)) begin
        errors++;
        $display("FAIL full_done_busy idx %0d: done=%b busy=%b required done=%b busy=%b",
                 i, done_s[i], busy_s[i], (i == 172), (i < 172));
      end
    end
  endtask

  task automatic test_ce_toggle();
    run_dump(1'b1);
    checks++;
    if (n_samp !== NS) begin
      errors++;
      $display("FAIL ce_timeout: samples %0d required %0d", n_samp, NS);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (decode(k) !== exp_bytes[k]) begin
        errors++;
        $display("FAIL ce_byte%0d: got %h required %h", k, decode(k), exp_bytes[k]);
      end
      checks++;
      if (!frame_shape_ok(k)) begin
        errors++;
        $display("FAIL ce_shape%0d: bit widths wrong, got 0 required 1", k);
      end
    end
    checks++;
    if (done_s[172] !== 1'b1 || done_s[171] !== 1'b0 || done_s[173] !== 1'b0) begin
      errors++;
      $display("FAIL ce_done: done[171..173]=%b%b%b required 010",
               done_s[171], done_s[172], done_s[173]);
    end
  endtask

  task automatic test_reset_mid_frame();
    ce = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 62; i++) step();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || ram_adr !== 8'h01) begin
      errors++;
      $display("FAIL pre_reset: tx=%b busy=%b adr=%h required tx=0 busy=1 adr=01",
               tx, busy, ram_adr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ram_adr !== 8'h00 || ram_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b adr=%h en=%b required tx=1 busy=0 adr=00 en=0",
               tx, busy, ram_adr, ram_enable);
    end
    step();
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
    run_dump(1'b0);
    checks++;
    if (en_s[0] !== 1'b1 || adr_s[0] !== 8'h00) begin
      errors++;
      $display("FAIL restart_adr: en=%b adr=%h required en=1 adr=00", en_s[0], adr_s[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (decode(k) !== exp_bytes[k]) begin
        errors++;
        $display("FAIL restart_byte%0d: got %h required %h", k, decode(k), exp_bytes[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_en;
    ce = 1'b1;
    start = 1'b1;
    step();
    for (int off = 1; off <= 173; off++) begin
      start = ((off >= 50 && off <= 55) || off >= 160);
      step();
      exp_en = (off == 43 || off == 86 || off == 129 || off == 173);
      checks++;
      if (done !== (off == 172) || busy !== (off != 172) || ram_enable !== exp_en) begin
        errors++;
        $display("FAIL b2b off %0d: done=%b busy=%b en=%b required done=%b busy=%b en=%b",
                 off, done, busy, ram_enable, (off == 172), (off != 172), exp_en);
      end
      if (exp_en) begin
        checks++;
        if (ram_adr !== 8'((off == 173) ? 0 : off / 43)) begin
          errors++;
          $display("FAIL b2b_adr off %0d: got %h required %h",
                   off, ram_adr, 8'((off == 173) ? 0 : off / 43));
        end
      end
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    ce = 1'b1;
    start = 1'b0;
    checks = 0;
    errors = 0;
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h3C;
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h00;
    exp_bytes[2] = 8'hFF; exp_bytes[3] = 8'h3C;

    test_reset();
    test_single_frame();
    test_full_dump();
    test_ce_toggle();
    test_reset_mid_frame();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
